// File: rtl/acounter_down.sv
`default_nettype none
// ============================================================================
//  Module      : acounter_down
//  Description : Loadable down-counter / timer. Counts a loaded value toward
//                zero while enabled, pulses a one-cycle terminal-count flag,
//                then stops (one-shot) or reloads (auto-reload).
//  Revision    : 1.0 - initial release
// ============================================================================
module acounter_down #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             d,
    input  logic             load,
    input  logic [WIDTH-1:0] ld_val,
    input  logic             mode,
    input  logic             stop,
    output logic [WIDTH-1:0] cq,
    output logic             tc,
    output logic             busy
);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    localparam logic [WIDTH-1:0] C_ONE  = WIDTH'(1);
    localparam logic [WIDTH-1:0] C_ZERO = '0;

    state_t           state_q,  state_d;
    logic [WIDTH-1:0] cq_q,     cq_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             mode_q,   mode_d;
    logic             tc_q,     tc_d;
    logic             busy_q,   busy_d;

    // Next-state logic: load beats stop, stop beats counting.
    always_comb begin
        state_d  = state_q;
        cq_d     = cq_q;
        reload_d = reload_q;
        mode_d   = mode_q;
        tc_d     = 1'b0;

        if (load) begin
            cq_d     = ld_val;
            reload_d = ld_val;
            mode_d   = mode;
            // A zero load parks the counter without ever raising tc.
            state_d  = (ld_val != C_ZERO) ? S_RUN : S_IDLE;
        end else if (stop) begin
            state_d  = S_IDLE;
        end else if ((state_q == S_RUN) && d) begin
            if (cq_q > C_ONE) begin
                cq_d = cq_q - C_ONE;
            end else begin
                // Terminal step: auto-reload skips zero so the period is
                // exactly the reload value in enabled cycles.
                tc_d = 1'b1;
                if (mode_q) begin
                    cq_d = reload_q;
                end else begin
                    cq_d    = C_ZERO;
                    state_d = S_IDLE;
                end
            end
        end

        busy_d = (state_d == S_RUN);
    end

    // State and output registers, cleared immediately by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cq_q     <= C_ZERO;
            reload_q <= C_ZERO;
            mode_q   <= 1'b0;
            tc_q     <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cq_q     <= cq_d;
            reload_q <= reload_d;
            mode_q   <= mode_d;
            tc_q     <= tc_d;
            busy_q   <= busy_d;
        end
    end

    assign cq   = cq_q;
    assign tc   = tc_q;
    assign busy = busy_q;

endmodule
`default_nettype wire
